// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester.
//   apb_state_e : FSM state encoding (IDLE/SETUP/ACCESS)
//   APB_*       : default bus widths and wait-state timeout
//   GPIO_*      : register map of the GPIO peripheral on this bus
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_TIMEOUT = 16;

  localparam logic [7:0] GPIO_DIR = 8'h10;
  localparam logic [7:0] GPIO_IN  = 8'h11;
  localparam logic [7:0] GPIO_OUT = 8'h12;

endpackage

// File: rtl/apb_master.sv
// APB requester: converts single-beat commands into APB SETUP/ACCESS
// transfers and returns one response per command. A wait-state timeout
// ends a transfer with an error if pready never arrives.
//
// Ports
//   pclk, preset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (ready only in IDLE)
//   cmd_write/addr/wdata    : command contents
//   rsp_valid/error/rdata   : one-cycle response; error = timeout
//   psel/penable/pwrite     : APB control
//   paddr/pw_data           : APB address / write data
//   prdata/pready           : APB read data / ready from peripheral
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pw_data,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value seen on the TIMEOUT-th ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_error_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pw_data_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;

  // cmd_ready is a register: it is low during reset and rises on the
  // first clock after reset release, so the handshake is cmd_valid &
  // cmd_ready_q rather than just being in IDLE.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      paddr_q     <= '0;
      pw_data_q   <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pw_data_q   <= cmd_wdata;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready on the last allowed cycle wins over the timeout.
          if (pready || (wait_cnt_q == CNT_LAST)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= ~pready;
            if (pready && !pwrite_q) begin
              rsp_rdata_q <= prdata;
            end
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign paddr     = paddr_q;
  assign pw_data   = pw_data_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus random
// transfers checked against a transfer-level model (access length,
// error flag and read-data register derived from the wait count).
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 16;

  logic       pclk;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_error;
  logic [7:0] rsp_rdata;
  logic [7:0] paddr;
  logic [7:0] pw_data;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] prdata;
  logic       pready;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [7:0] exp_rdata;

  // observations of one transfer
  int   obs_setup;
  int   obs_access;
  logic obs_ready;
  logic obs_got;
  logic obs_err;
  logic obs_addr_ok;
  logic obs_psel_rsp;
  logic obs_rv_next;

  apb_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(TO)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata),
    .paddr    (paddr),
    .pw_data  (pw_data),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Issue one command and act as a slave that raises pready on ACCESS
  // cycle waits+1 (never, if waits is large). junk drives pready high
  // outside ACCESS, which the requester must ignore.
  task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input logic [7:0] rv, input logic junk);
    obs_setup = 0; obs_access = 0; obs_got = 0; obs_err = 0;
    obs_addr_ok = 1; obs_psel_rsp = 1; obs_rv_next = 1;
    @(negedge pclk);
    for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge pclk);
    obs_ready = cmd_ready;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    prdata = rv; pready = junk;
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_addr = ~a; cmd_wdata = ~d; cmd_write = ~w;
    for (int c = 0; c < 200 && !obs_got; c++) begin
      if (rsp_valid) begin
        obs_got = 1'b1;
        obs_err = rsp_error;
        obs_psel_rsp = psel | penable;
        pready = 1'b0;
      end else begin
        if (psel && !penable) begin
          obs_setup++;
          pready = junk;
        end else if (psel && penable) begin
          obs_access++;
          if (paddr !== a || pwrite !== w || (w && pw_data !== d)) obs_addr_ok = 1'b0;
          pready = (obs_access == waits + 1);
          prdata = pready ? rv : ~rv;
        end else begin
          pready = 1'b0;
        end
        @(negedge pclk);
      end
    end
    @(negedge pclk);
    obs_rv_next = rsp_valid;
  endtask

  task automatic model_xfer(input logic w, input int waits, input logic [7:0] rv,
                            output int exp_acc, output logic exp_err);
    exp_err = (waits >= TO);
    exp_acc = exp_err ? TO : waits + 1;
    if (!w && !exp_err) exp_rdata = rv;
  endtask

  task automatic test_reset();
    preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = GPIO_OUT; cmd_wdata = 8'hFF; pready = 1'b1; prdata = 8'h55;
    repeat (3) @(negedge pclk);
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pw_data, rsp_valid, rsp_error, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b %b %b %h %h %b %b %h required all zero",
               psel, penable, pwrite, paddr, pw_data, rsp_valid, rsp_error, rsp_rdata);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    preset = 1'b0;
    @(negedge pclk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      n_bad++;
      $display("FAIL release_ready: cmd_ready=%b psel=%b required 1/0", cmd_ready, psel);
    end
    cmd_valid = 1'b0; pready = 1'b0;
    exp_rdata = 8'h00;
  endtask

  task automatic test_write_zero_wait();
    int ea; logic ee;
    run_xfer(1'b1, GPIO_OUT, 8'hA5, 0, 8'h77, 1'b0);
    model_xfer(1'b1, 0, 8'h77, ea, ee);
    n_cmp++;
    if (obs_setup !== 1 || obs_access !== ea) begin
      n_bad++;
      $display("FAIL wr_phases: setup=%0d access=%0d required 1/%0d", obs_setup, obs_access, ea);
    end
    n_cmp++;
    if (obs_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL wr_bus_fields: got mismatch on paddr/pwrite/pw_data required 12/1/a5");
    end
    n_cmp++;
    if (obs_got !== 1'b1 || obs_err !== ee) begin
      n_bad++; $display("FAIL wr_rsp: got valid=%b err=%b required 1/%b", obs_got, obs_err, ee);
    end
    n_cmp++;
    if (rsp_rdata !== exp_rdata) begin
      n_bad++; $display("FAIL wr_rdata_kept: got %h required %h", rsp_rdata, exp_rdata);
    end
    n_cmp++;
    if (obs_psel_rsp !== 1'b0 || obs_rv_next !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_after: psel|penable=%b rsp_valid_next=%b required 0/0", obs_psel_rsp, obs_rv_next);
    end
  endtask

  task automatic test_read_wait();
    int ea; logic ee;
    run_xfer(1'b0, GPIO_IN, 8'h00, 3, 8'h3C, 1'b0);
    model_xfer(1'b0, 3, 8'h3C, ea, ee);
    n_cmp++;
    if (obs_access !== ea || obs_addr_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_wait_access: access=%0d stable=%b required %0d/1", obs_access, obs_addr_ok, ea);
    end
    n_cmp++;
    if (obs_got !== 1'b1 || obs_err !== ee || rsp_rdata !== exp_rdata) begin
      n_bad++;
      $display("FAIL rd_wait_rsp: valid=%b err=%b rdata=%h required 1/%b/%h",
               obs_got, obs_err, rsp_rdata, ee, exp_rdata);
    end
  endtask

  task automatic test_timeout();
    int ea; logic ee;
    run_xfer(1'b0, GPIO_IN, 8'h00, 1000, 8'hC3, 1'b0);
    model_xfer(1'b0, 1000, 8'hC3, ea, ee);
    n_cmp++;
    if (obs_access !== ea) begin
      n_bad++; $display("FAIL to_access: got %0d required %0d", obs_access, ea);
    end
    n_cmp++;
    if (obs_got !== 1'b1 || obs_err !== ee || obs_psel_rsp !== 1'b0) begin
      n_bad++;
      $display("FAIL to_rsp: valid=%b err=%b psel=%b required 1/%b/0", obs_got, obs_err, obs_psel_rsp, ee);
    end
    n_cmp++;
    if (rsp_rdata !== exp_rdata) begin
      n_bad++; $display("FAIL to_rdata_kept: got %h required %h", rsp_rdata, exp_rdata);
    end
  endtask

  task automatic test_late_ready();
    int ea; logic ee;
    run_xfer(1'b0, GPIO_DIR, 8'h00, TO - 1, 8'h5A, 1'b0);
    model_xfer(1'b0, TO - 1, 8'h5A, ea, ee);
    n_cmp++;
    if (obs_access !== ea || obs_err !== ee || obs_got !== 1'b1 || rsp_rdata !== exp_rdata) begin
      n_bad++;
      $display("FAIL late_ready: access=%0d err=%b valid=%b rdata=%h required %0d/%b/1/%h",
               obs_access, obs_err, obs_got, rsp_rdata, ea, ee, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int ea; logic ee; int seen;
    logic [7:0] rv;
    @(negedge pclk);
    for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO_OUT; cmd_wdata = 8'h99; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    n_cmp++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_bad++; $display("FAIL mid_in_access: psel=%b penable=%b required 1/1", psel, penable);
    end
    preset = 1'b1;
    @(negedge pclk);
    n_cmp++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_drop: psel=%b penable=%b rsp_valid=%b required 0/0/0", psel, penable, rsp_valid);
    end
    preset = 1'b0;
    exp_rdata = 8'h00;
    seen = 0;
    repeat (6) begin
      @(negedge pclk);
      if (rsp_valid || psel) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL mid_no_rsp: got %0d active cycles required 0", seen);
    end
    rv = 8'($urandom);
    run_xfer(1'b0, GPIO_DIR, 8'h00, 2, rv, 1'b0);
    model_xfer(1'b0, 2, rv, ea, ee);
    n_cmp++;
    if (obs_ready !== 1'b1 || obs_got !== 1'b1 || obs_err !== ee ||
        obs_access !== ea || rsp_rdata !== exp_rdata) begin
      n_bad++;
      $display("FAIL mid_next_read: ready=%b valid=%b err=%b access=%0d rdata=%h required 1/1/%b/%0d/%h",
               obs_ready, obs_got, obs_err, obs_access, rsp_rdata, ee, ea, exp_rdata);
    end
  endtask

  task automatic test_random();
    int ea; logic ee; int waits;
    logic w, junk; logic [7:0] a, d, rv;
    for (int k = 0; k < 24; k++) begin
      w     = 1'($urandom);
      a     = 8'($urandom);
      d     = 8'($urandom);
      rv    = 8'($urandom);
      junk  = 1'($urandom);
      waits = $urandom_range(0, TO + 3);
      run_xfer(w, a, d, waits, rv, junk);
      model_xfer(w, waits, rv, ea, ee);
      n_cmp++;
      if (obs_got !== 1'b1 || obs_err !== ee || obs_setup !== 1 || obs_access !== ea ||
          obs_addr_ok !== 1'b1 || rsp_rdata !== exp_rdata ||
          obs_psel_rsp !== 1'b0 || obs_rv_next !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_%0d: w=%b waits=%0d valid=%b err=%b setup=%0d access=%0d stable=%b rdata=%h idle=%b next=%b required 1/%b/1/%0d/1/%h/0/0",
                 k, w, waits, obs_got, obs_err, obs_setup, obs_access, obs_addr_ok, rsp_rdata,
                 obs_psel_rsp, obs_rv_next, ee, ea, exp_rdata);
      end
    end
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; prdata = '0; pready = 1'b0; exp_rdata = '0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_late_ready();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
